// File: rtl/log_pkg.sv
// Shared constants and FSM state type for the flag-word unpacker.
// Bit order is selected by LOG_UNPACK_MSB_FIRST_EN (see log_prienc).
package log_pkg;

    localparam int LOG_WIDTH = 16;
    localparam int LOG_IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/log_prienc.sv
// Combinational priority encoder: picks the next set bit to report and flags a single-bit vector.
// Define LOG_UNPACK_MSB_FIRST_EN to pick the highest set bit instead of the lowest.
module log_prienc
    import log_pkg::*;
#(
    parameter int WIDTH = LOG_WIDTH,
    parameter int IDX_W = LOG_IDX_W
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             onehot_o
);

    // Later loop iterations win, so the loop direction sets the priority.
    always_comb begin
        idx_o = '0;
`ifdef LOG_UNPACK_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
`endif
    end

    assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/log_unpack.sv
// Splits an accepted flag word into one out_idx beat per set bit (inverse of an OR flag merge).
// Emission order follows LOG_UNPACK_MSB_FIRST_EN; default build reports lowest index first.
module log_unpack
    import log_pkg::*;
#(
    parameter int WIDTH = LOG_WIDTH,
    parameter int IDX_W = LOG_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             zero_word,
    output logic             busy
);

    state_t           state_q;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             out_valid_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_last_q;
    logic             zero_word_q;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_onehot;

    // The encoder looks at the next shadow value so the beat outputs can be registered.
    always_comb begin
        shadow_d = shadow_q;
        if (state_q == IDLE) begin
            if (in_valid && (in_word != '0)) shadow_d = in_word;
        end else if (out_ready) begin
            shadow_d = shadow_q & ~(WIDTH'(1) << out_idx_q);
        end
    end

    log_prienc #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_prienc (
        .vec_i    (shadow_d),
        .idx_o    (enc_idx),
        .onehot_o (enc_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shadow_q    <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            zero_word_q <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            zero_word_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (in_word != '0) begin
                            state_q     <= SCAN;
                            out_valid_q <= 1'b1;
                            out_idx_q   <= enc_idx;
                            out_last_q  <= enc_onehot;
                        end else begin
                            zero_word_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_idx_q   <= '0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_idx_q  <= enc_idx;
                            out_last_q <= enc_onehot;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SCAN);
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign zero_word = zero_word_q;

endmodule

// File: tb/tb_log_unpack.sv
// Self-checking bench for log_unpack: directed cases plus random words against a bit-list model.
// Honours LOG_UNPACK_MSB_FIRST_EN in the model so either build can be checked.
module tb_log_unpack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_last;
    logic        zero_word;
    logic        busy;

    int vectors;
    int miscompares;

    log_unpack #(
        .WIDTH (16),
        .IDX_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .zero_word (zero_word),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 1);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_out_idx"}, 32'(out_idx), 0);
        checkOutput({tag, "_out_last"}, 32'(out_last), 0);
    endtask

    // Offers one word in IDLE, then drains it while comparing each beat with the expected bit list.
    task automatic applyStimulus(input logic [15:0] w, input int stallFirst, input bit randReady);
        int q[$];
        int stall;
        int guard;
        q.delete();
        for (int i = 0; i < 16; i++) begin
            if (w[i]) begin
`ifdef LOG_UNPACK_MSB_FIRST_EN
                q.push_front(i);
`else
                q.push_back(i);
`endif
            end
        end

        @(negedge clk);
        checkIdle("pre_accept");
        in_valid  = 1'b1;
        in_word   = w;
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        in_valid = 1'b0;

        if (w == 16'h0000) begin
            checkOutput("zero_pulse", 32'(zero_word), 1);
            checkOutput("zero_no_valid", 32'(out_valid), 0);
            checkOutput("zero_in_ready", 32'(in_ready), 1);
            @(negedge clk);
            checkOutput("zero_pulse_end", 32'(zero_word), 0);
            checkOutput("zero_still_idle", 32'(out_valid), 0);
            return;
        end

        checkOutput("nonzero_no_pulse", 32'(zero_word), 0);
        stall = stallFirst;
        guard = 0;
        while (q.size() > 0 && guard < 400) begin
            guard++;
            checkOutput("beat_valid", 32'(out_valid), 1);
            checkOutput("beat_busy", 32'(busy), 1);
            checkOutput("beat_in_ready", 32'(in_ready), 0);
            checkOutput("beat_idx", 32'(out_idx), q[0]);
            checkOutput("beat_last", 32'(out_last), (q.size() == 1) ? 1 : 0);
            in_valid = 1'($urandom_range(0, 1));
            in_word  = 16'($urandom);
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else if (randReady) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (out_ready) void'(q.pop_front());
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("drain_bound", q.size(), 0);
        checkIdle("post_drain");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_word     = 16'h0000;
        out_ready   = 1'b0;

        repeat (2) @(negedge clk);
        checkIdle("reset");
        checkOutput("reset_zero_word", 32'(zero_word), 0);
        rst_n = 1'b1;
        checkOutput("reset_release_ready", 32'(in_ready), 1);

        applyStimulus(16'h0000, 0, 1'b0);
        applyStimulus(16'h8421, 0, 1'b0);
        applyStimulus(16'h0006, 3, 1'b0);
        applyStimulus(16'hFFFF, 0, 1'b0);

        // Reset two beats into 16'h00F0 must drop the remaining bits.
        @(negedge clk);
        in_valid  = 1'b1;
        in_word   = 16'h00F0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
`ifdef LOG_UNPACK_MSB_FIRST_EN
        checkOutput("rst_mid_beat0", 32'(out_idx), 7);
        @(negedge clk);
        checkOutput("rst_mid_beat1", 32'(out_idx), 6);
        @(negedge clk);
        checkOutput("rst_mid_beat2", 32'(out_idx), 5);
`else
        checkOutput("rst_mid_beat0", 32'(out_idx), 4);
        @(negedge clk);
        checkOutput("rst_mid_beat1", 32'(out_idx), 5);
        @(negedge clk);
        checkOutput("rst_mid_beat2", 32'(out_idx), 6);
`endif
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_valid", 32'(out_valid), 0);
        checkOutput("rst_mid_busy", 32'(busy), 0);
        checkOutput("rst_mid_last", 32'(out_last), 0);
        rst_n     = 1'b1;
        out_ready = 1'b0;
        checkOutput("rst_mid_ready", 32'(in_ready), 1);
        @(negedge clk);
        checkOutput("rst_mid_no_beats", 32'(out_valid), 0);
        applyStimulus(16'h0001, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [15:0] w;
            w = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            applyStimulus(w, int'($urandom_range(0, 2)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
